mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle CPU main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
//  Drives all datapath strobes and mux selects, including the 3-bit alu_ctrl and
//  alu_ctrl_sel feeding the 3-bit 2:1 ALU-op mux.
//  Stalls on memory via a ready handshake and combines the branch/zero decision into pc_en.
// PARAMETERS
//  MEM_WAIT  1  1: FETCH/MEMRD/MEMWR hold until mem_ready; 0: mem_ready ignored (1-cycle memory)
//  STATE_W   4  state register width; fixed encodings below
// PORTS
//  clk           in   1  single clock, rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  opcode        in   6  IR[31:26], valid from DECODE onward
//  funct         in   6  IR[5:0]
//  zero          in   1  ALU zero flag, sampled in BRANCH
//  mem_ready     in   1  memory access completes this cycle
//  pc_en         out  1  PC load enable (branch decision already applied)
//  i_or_d        out  1  0=PC addresses memory, 1=ALUOut
//  mem_read      out  1  memory read request
//  mem_write     out  1  memory write request
//  ir_write      out  1  IR load
//  reg_dst       out  1  0=rt, 1=rd
//  mem_to_reg    out  1  0=ALUOut, 1=MDR
//  reg_write     out  1  register file write
//  alu_src_a     out  1  0=PC, 1=A
//  alu_src_b     out  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
//  pc_source     out  2  00=ALU, 01=ALUOut, 10=jump target
//  alu_ctrl      out  3  decoded operation (mux input B)
//  alu_ctrl_sel  out  1  0=forced ADD (mux input A=010), 1=alu_ctrl
//  illegal_op    out  1  1-cycle pulse on unknown opcode/funct
//  state         out  4  current state, for debug
// BEHAVIOUR
//  States: INIT=F, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6,
//   RTWB=7, BRANCH=8, JUMP=9, IMMEX=A, IMMWB=B. Outputs decoded from state only (plus zero, funct, opcode).
//  Reset: state<=INIT asynchronously; in INIT all outputs 0 (alu_ctrl=010, state=F); INIT->FETCH next edge.
//  FETCH: mem_read, ir_write, alu_src_b=01, pc_source=00, alu_ctrl_sel=0; pc_en=ir_write=mem_ready
//   (1 when MEM_WAIT=0). Stay while !mem_ready; ->DECODE when ready.
//  DECODE: alu_src_b=11, alu_ctrl_sel=0 (branch target precompute). Next by opcode:
//   00->RTEX; 23/2B->MEMADR; 04/05->BRANCH; 02->JUMP; 08/0C/0D/0A->IMMEX;
//   other -> FETCH with illegal_op=1 during DECODE.
//  MEMADR: alu_src_a=1, alu_src_b=10, add; ->MEMRD (23) or MEMWR (2B).
//  MEMRD: mem_read, i_or_d=1; wait on mem_ready; ->MEMWB. MEMWB: reg_write, mem_to_reg=1, reg_dst=0; ->FETCH.
//  MEMWR: mem_write, i_or_d=1; wait on mem_ready; ->FETCH.
//  RTEX: alu_src_a=1, alu_src_b=00, alu_ctrl_sel=1; funct 20 add=010, 22 sub=110, 24 and=000,
//   25 or=001, 27 nor=100, 2A slt=111; other funct: illegal_op pulse, ->FETCH, no writeback. Else ->RTWB.
//  RTWB: reg_write, reg_dst=1, mem_to_reg=0; ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl_sel=1, alu_ctrl=110, pc_source=01;
//   pc_en = zero for 04 (beq), ~zero for 05 (bne); ->FETCH.
//  JUMP: pc_source=10, pc_en=1; ->FETCH.
//  IMMEX: alu_src_a=1, alu_src_b=10, alu_ctrl_sel=1; 08 add, 0C and, 0D or, 0A slt; ->IMMWB.
//  IMMWB: reg_write, reg_dst=0, mem_to_reg=0; ->FETCH.
//  Strobes are 0 in every state not listing them; mem_read and mem_write never both 1.
//  Wait states hold all outputs stable; only the completing cycle asserts pc_en/ir_write.
//  rst_n low mid-access: immediate INIT, all strobes drop same cycle (async), no partial write.
//  Unreachable state codes (C-E) -> FETCH next edge, outputs 0.
//  CPI: R/imm 4, lw 5, sw 4, beq/bne/j 3 (+wait cycles).
// STRUCTURE
//  Shared package mc_cpu_pkg: state encodings, opcode/funct constants, ALU op codes, alu_src_b/pc_source codes.
//  One sub-module mc_alu_decode (opcode, funct -> alu_ctrl, legal); FSM core in this module.
// TESTING
//  Reset held 3 cycles, release -> state F one cycle, then 0; all strobes 0 while rst_n=0.
//  add (op 00, funct 20), mem_ready=1 -> states 0,1,6,7,0; alu_ctrl=010 in RTEX; reg_write only in RTWB.
//  lw (op 23), mem_ready low 2 cycles in FETCH and MEMRD -> FETCH 3 cycles, pc_en exactly once; MEMWB mem_to_reg=1.
//  beq zero=1 -> pc_en=1, pc_source=01 in BRANCH; bne zero=1 -> pc_en=0.
//  op 3F -> illegal_op=1 in DECODE, next state 0; op 00 funct 3F -> illegal_op in RTEX, no reg_write.
//  rst_n low during MEMWR with mem_ready=0 -> mem_write falls without clock edge, state=F.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - shared encodings for the multi-cycle CPU controller
package mc_cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MEMADR = 4'h2,
        S_MEMRD  = 4'h3,
        S_MEMWB  = 4'h4,
        S_MEMWR  = 4'h5,
        S_RTEX   = 4'h6,
        S_RTWB   = 4'h7,
        S_BRANCH = 4'h8,
        S_JUMP   = 4'h9,
        S_IMMEX  = 4'hA,
        S_IMMWB  = 4'hB,
        S_INIT   = 4'hF
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - opcode/funct to ALU operation decode with legality flag
module mc_alu_decode
    import mc_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: legal    = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_J: alu_ctrl = ALU_ADD;
            OP_BEQ, OP_BNE:     alu_ctrl = ALU_SUB;
            OP_ADDI:            alu_ctrl = ALU_ADD;
            OP_ANDI:            alu_ctrl = ALU_AND;
            OP_ORI:             alu_ctrl = ALU_OR;
            OP_SLTI:            alu_ctrl = ALU_SLT;
            default:            legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle CPU main controller (Moore FSM)
module mc_ctrl_fsm
    import mc_cpu_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [2:0]         alu_ctrl,
    output logic               alu_ctrl_sel,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_e     state_q, state_d;
    logic       mem_ok;
    logic [2:0] dec_ctrl;
    logic       dec_legal;

    mc_alu_decode u_alu_decode (
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .legal    (dec_legal)
    );

    // With a single-cycle memory the ready handshake is ignored entirely.
    assign mem_ok = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        pc_source    = PCSRC_ALU;
        alu_ctrl     = ALU_ADD;
        alu_ctrl_sel = 1'b0;
        illegal_op   = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                // PC+4 and IR load commit only on the cycle the read completes.
                mem_read  = 1'b1;
                ir_write  = mem_ok;
                pc_en     = mem_ok;
                alu_src_b = SRCB_FOUR;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:       state_d = S_RTEX;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default: begin
                        if (is_imm_op(opcode)) begin
                            state_d = S_IMMEX;
                        end else begin
                            illegal_op = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end
            S_RTEX: begin
                alu_src_a    = 1'b1;
                alu_ctrl_sel = 1'b1;
                alu_ctrl     = dec_ctrl;
                if (dec_legal) begin
                    state_d = S_RTWB;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_ctrl_sel = 1'b1;
                alu_ctrl     = ALU_SUB;
                pc_source    = PCSRC_ALUOUT;
                pc_en        = (opcode == OP_BNE) ? ~zero : zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
                state_d   = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_ctrl_sel = 1'b1;
                alu_ctrl     = dec_ctrl;
                state_d      = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, alu_ctrl_sel, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic [14:0] strb;

    int pass_cnt = 0;
    int total_cnt = 0;

    mc_ctrl_fsm #(.MEM_WAIT(1), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctrl(alu_ctrl),
        .alu_ctrl_sel(alu_ctrl_sel), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign strb = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl_sel, illegal_op};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'h23; funct = 6'h20; zero = 1'b1; mem_ready = 1'b1;
        repeat (3) tick();
        total_cnt++; if (state !== 4'hF) $display("FAIL rst_state: got %h want F", state); else pass_cnt++;
        total_cnt++; if (strb !== 15'h0) $display("FAIL rst_strobes: got %h want 0", strb); else pass_cnt++;
        total_cnt++; if (alu_ctrl !== 3'b010) $display("FAIL rst_alu_ctrl: got %b want 010", alu_ctrl); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (state !== 4'hF) $display("FAIL rel_state_init: got %h want F", state); else pass_cnt++;
        tick();
        total_cnt++; if (state !== 4'h0) $display("FAIL rel_state_fetch: got %h want 0", state); else pass_cnt++;
    endtask

    task automatic test_add();
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
        #1;
        total_cnt++; if ({mem_read, ir_write, pc_en, alu_src_b, alu_ctrl_sel} !== 6'b111010)
            $display("FAIL add_fetch: got %b want 111010", {mem_read, ir_write, pc_en, alu_src_b, alu_ctrl_sel}); else pass_cnt++;
        tick();
        total_cnt++; if ({state, alu_src_b} !== {4'h1, 2'b11}) $display("FAIL add_decode: got %h/%b want 1/11", state, alu_src_b); else pass_cnt++;
        tick();
        total_cnt++; if ({state, alu_ctrl, alu_ctrl_sel, alu_src_a, alu_src_b, reg_write} !== {4'h6, 3'b010, 1'b1, 1'b1, 2'b00, 1'b0})
            $display("FAIL add_rtex: got %h %b %b %b %b %b", state, alu_ctrl, alu_ctrl_sel, alu_src_a, alu_src_b, reg_write); else pass_cnt++;
        tick();
        total_cnt++; if ({state, reg_write, reg_dst, mem_to_reg} !== {4'h7, 3'b110})
            $display("FAIL add_rtwb: got %h %b%b%b want 7 110", state, reg_write, reg_dst, mem_to_reg); else pass_cnt++;
        tick();
        total_cnt++; if (state !== 4'h0) $display("FAIL add_back_fetch: got %h want 0", state); else pass_cnt++;
    endtask

    task automatic test_lw_wait();
        int fetch_cycles = 0;
        int pe_count = 0;
        opcode = 6'h23;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            if (state == 4'h0) fetch_cycles++;
            if (pc_en) pe_count++;
            if (i == 0) begin
                total_cnt++; if ({mem_read, ir_write, pc_en} !== 3'b100)
                    $display("FAIL lw_fetch_wait: got %b want 100", {mem_read, ir_write, pc_en}); else pass_cnt++;
            end
            tick();
        end
        total_cnt++; if (fetch_cycles !== 3) $display("FAIL lw_fetch_cycles: got %0d want 3", fetch_cycles); else pass_cnt++;
        total_cnt++; if (pe_count !== 1) $display("FAIL lw_pc_en_count: got %0d want 1", pe_count); else pass_cnt++;
        total_cnt++; if (state !== 4'h1) $display("FAIL lw_decode: got %h want 1", state); else pass_cnt++;
        mem_ready = 1'b0;
        tick();
        total_cnt++; if ({state, alu_src_a, alu_src_b, alu_ctrl_sel} !== {4'h2, 1'b1, 2'b10, 1'b0})
            $display("FAIL lw_memadr: got %h %b %b %b", state, alu_src_a, alu_src_b, alu_ctrl_sel); else pass_cnt++;
        tick();
        total_cnt++; if ({state, mem_read, i_or_d, mem_write} !== {4'h3, 3'b110})
            $display("FAIL lw_memrd: got %h %b%b%b want 3 110", state, mem_read, i_or_d, mem_write); else pass_cnt++;
        tick();
        total_cnt++; if ({state, mem_read} !== {4'h3, 1'b1}) $display("FAIL lw_memrd_hold: got %h %b want 3 1", state, mem_read); else pass_cnt++;
        mem_ready = 1'b1;
        tick();
        total_cnt++; if ({state, reg_write, mem_to_reg, reg_dst} !== {4'h4, 3'b110})
            $display("FAIL lw_memwb: got %h %b%b%b want 4 110", state, reg_write, mem_to_reg, reg_dst); else pass_cnt++;
        tick();
        total_cnt++; if (state !== 4'h0) $display("FAIL lw_back_fetch: got %h want 0", state); else pass_cnt++;
    endtask

    task automatic test_branch_jump();
        mem_ready = 1'b1; opcode = 6'h04; zero = 1'b1;
        tick(); tick();
        total_cnt++; if ({state, pc_en, pc_source, alu_ctrl, alu_ctrl_sel} !== {4'h8, 1'b1, 2'b01, 3'b110, 1'b1})
            $display("FAIL beq_taken: got %h %b %b %b %b", state, pc_en, pc_source, alu_ctrl, alu_ctrl_sel); else pass_cnt++;
        tick();
        opcode = 6'h05; zero = 1'b1;
        tick(); tick();
        total_cnt++; if ({state, pc_en} !== {4'h8, 1'b0}) $display("FAIL bne_not_taken: got %h %b want 8 0", state, pc_en); else pass_cnt++;
        zero = 1'b0;
        #1;
        total_cnt++; if (pc_en !== 1'b1) $display("FAIL bne_taken: got %b want 1", pc_en); else pass_cnt++;
        tick();
        opcode = 6'h02;
        tick(); tick();
        total_cnt++; if ({state, pc_en, pc_source} !== {4'h9, 1'b1, 2'b10})
            $display("FAIL jump: got %h %b %b want 9 1 10", state, pc_en, pc_source); else pass_cnt++;
        tick();
        total_cnt++; if (state !== 4'h0) $display("FAIL jump_back_fetch: got %h want 0", state); else pass_cnt++;
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1; opcode = 6'h3F;
        tick();
        total_cnt++; if ({state, illegal_op} !== {4'h1, 1'b1}) $display("FAIL ill_op_decode: got %h %b want 1 1", state, illegal_op); else pass_cnt++;
        tick();
        total_cnt++; if ({state, illegal_op} !== {4'h0, 1'b0}) $display("FAIL ill_op_next: got %h %b want 0 0", state, illegal_op); else pass_cnt++;
        opcode = 6'h00; funct = 6'h3F;
        tick(); tick();
        total_cnt++; if ({state, illegal_op, reg_write} !== {4'h6, 2'b10})
            $display("FAIL ill_funct_rtex: got %h %b %b want 6 1 0", state, illegal_op, reg_write); else pass_cnt++;
        tick();
        total_cnt++; if ({state, reg_write} !== {4'h0, 1'b0}) $display("FAIL ill_funct_no_wb: got %h %b want 0 0", state, reg_write); else pass_cnt++;
    endtask

    task automatic test_imm();
        mem_ready = 1'b1; opcode = 6'h0D;
        tick(); tick();
        total_cnt++; if ({state, alu_ctrl, alu_ctrl_sel, alu_src_a, alu_src_b} !== {4'hA, 3'b001, 1'b1, 1'b1, 2'b10})
            $display("FAIL ori_immex: got %h %b %b %b %b", state, alu_ctrl, alu_ctrl_sel, alu_src_a, alu_src_b); else pass_cnt++;
        tick();
        total_cnt++; if ({state, reg_write, reg_dst, mem_to_reg} !== {4'hB, 3'b100})
            $display("FAIL ori_immwb: got %h %b%b%b want B 100", state, reg_write, reg_dst, mem_to_reg); else pass_cnt++;
        tick();
        opcode = 6'h0A;
        tick(); tick();
        total_cnt++; if ({state, alu_ctrl} !== {4'hA, 3'b111}) $display("FAIL slti_immex: got %h %b want A 111", state, alu_ctrl); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (state !== 4'h0) $display("FAIL slti_back_fetch: got %h want 0", state); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        mem_ready = 1'b1; opcode = 6'h2B;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        total_cnt++; if ({state, mem_write, mem_read, i_or_d} !== {4'h5, 3'b101})
            $display("FAIL sw_memwr: got %h %b%b%b want 5 101", state, mem_write, mem_read, i_or_d); else pass_cnt++;
        tick();
        total_cnt++; if ({state, mem_write} !== {4'h5, 1'b1}) $display("FAIL sw_memwr_hold: got %h %b want 5 1", state, mem_write); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({state, mem_write, strb} !== {4'hF, 1'b0, 15'h0})
            $display("FAIL async_rst_drop: got %h %b %h want F 0 0", state, mem_write, strb); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (state !== 4'h0) $display("FAIL rst_recover: got %h want 0", state); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch_jump();
        test_illegal();
        test_imm();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
